// File: rtl/expr_stream_checker_if.sv
// Character stream and status bundle for expr_stream_checker.
// The master drives characters; the slave (the checker) reports status.
interface expr_stream_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [7:0]       in;
    logic             out;
    logic             err;
    logic [CNT_W-1:0] err_pos;
    logic [7:0]       depth;
    logic [CNT_W-1:0] char_cnt;

    modport master (
        output in_valid, in,
        input  out, err, err_pos, depth, char_cnt
    );

    modport slave (
        input  in_valid, in,
        output out, err, err_pos, depth, char_cnt
    );
endinterface

// File: rtl/expr_stream_checker.sv
// Streaming ASCII arithmetic-expression validator, one character per accepted cycle.
// Tracks operand length and parenthesis depth; a syntax error is sticky until clr.
module expr_stream_checker #(
    parameter int         MAX_DIGITS = 4,
    parameter int         MAX_DEPTH  = 7,
    parameter logic [3:0] OP_MASK    = 4'b0101,
    parameter bit         SKIP_SPACE = 1'b1,
    parameter int         CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    expr_stream_checker_if.slave  bus
);

    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_EXPECT = 2'd0,
        S_NUM    = 2'd1,
        S_AOP    = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [7:0]         depth_q, depth_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   err_pos_q, err_pos_d;

    logic is_dig, is_op, is_lp, is_rp, is_sp;
    logic go_err;

    // Disabled operators fall through to OTHER and therefore raise an error.
    always_comb begin
        is_dig = (bus.in >= 8'h30) && (bus.in <= 8'h39);
        is_lp  = (bus.in == 8'h28);
        is_rp  = (bus.in == 8'h29);
        is_sp  = SKIP_SPACE && (bus.in == 8'h20);
        unique case (bus.in)
            8'h2B:   is_op = OP_MASK[0];
            8'h2D:   is_op = OP_MASK[1];
            8'h2A:   is_op = OP_MASK[2];
            8'h2F:   is_op = OP_MASK[3];
            default: is_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        depth_d   = depth_q;
        cnt_d     = cnt_q;
        err_pos_d = err_pos_q;
        go_err    = 1'b0;

        if (bus.in_valid) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;

            unique case (state_q)
                S_EXPECT: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        dcnt_d  = DCNT_W'(1);
                    end else if (is_lp) begin
                        if (depth_q < 8'(MAX_DEPTH)) depth_d = depth_q + 8'd1;
                        else                         go_err  = 1'b1;
                    end else if (!is_sp) begin
                        go_err = 1'b1;
                    end
                end
                S_NUM: begin
                    if (is_dig) begin
                        if (dcnt_q < DCNT_W'(MAX_DIGITS)) dcnt_d = dcnt_q + 1'b1;
                        else                              go_err = 1'b1;
                    end else if (is_op) begin
                        state_d = S_EXPECT;
                    end else if (is_rp) begin
                        if (depth_q != 8'd0) begin
                            depth_d = depth_q - 8'd1;
                            state_d = S_AOP;
                        end else begin
                            go_err = 1'b1;
                        end
                    end else if (is_sp) begin
                        state_d = S_AOP;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                S_AOP: begin
                    if (is_op) begin
                        state_d = S_EXPECT;
                    end else if (is_rp) begin
                        if (depth_q != 8'd0) depth_d = depth_q - 8'd1;
                        else                 go_err  = 1'b1;
                    end else if (!is_sp) begin
                        go_err = 1'b1;
                    end
                end
                default: ;
            endcase

            // The offending character's index is the post-increment count.
            if (go_err) begin
                state_d   = S_ERR;
                err_pos_d = cnt_d;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_EXPECT;
            dcnt_q    <= '0;
            depth_q   <= '0;
            cnt_q     <= '0;
            err_pos_q <= '0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            depth_q   <= depth_d;
            cnt_q     <= cnt_d;
            err_pos_q <= err_pos_d;
        end
    end

    assign bus.err      = (state_q == S_ERR);
    assign bus.out      = ((state_q == S_NUM) || (state_q == S_AOP)) && (depth_q == 8'd0);
    assign bus.err_pos  = err_pos_q;
    assign bus.depth    = depth_q;
    assign bus.char_cnt = cnt_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed test of expr_stream_checker: three parameterisations share one character
// stream, and each check targets the instance whose parameters the case exercises.
module tb_expr_stream_checker;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_ch = 8'h00;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    expr_stream_checker_if #(.CNT_W(16)) if_a ();
    expr_stream_checker_if #(.CNT_W(16)) if_b ();
    expr_stream_checker_if #(.CNT_W(4))  if_c ();

    assign if_a.in_valid = in_valid;
    assign if_a.in       = in_ch;
    assign if_b.in_valid = in_valid;
    assign if_b.in       = in_ch;
    assign if_c.in_valid = in_valid;
    assign if_c.in       = in_ch;

    expr_stream_checker dut_a (
        .clk (clk),
        .clr (clr),
        .bus (if_a)
    );

    expr_stream_checker #(.MAX_DIGITS(3)) dut_b (
        .clk (clk),
        .clr (clr),
        .bus (if_b)
    );

    expr_stream_checker #(.MAX_DEPTH(2), .SKIP_SPACE(1'b0), .CNT_W(4)) dut_c (
        .clk (clk),
        .clr (clr),
        .bus (if_c)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input byte c);
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    initial begin
        string t1;
        string t1_out;
        int    t2_depth [7];

        t1       = "12+3*45";
        t1_out   = "1101011";
        t2_depth = '{1, 1, 1, 2, 2, 1, 0};

        pulseReset();
        @(posedge clk);
        #1;
        checkOutput("rst_out",     if_a.out,      0);
        checkOutput("rst_err",     if_a.err,      0);
        checkOutput("rst_err_pos", if_a.err_pos,  0);
        checkOutput("rst_depth",   if_a.depth,    0);
        checkOutput("rst_cnt",     if_a.char_cnt, 0);

        // T1: multi-digit operands with '+' and '*'
        for (int i = 0; i < t1.len(); i++) begin
            applyStimulus(t1[i]);
            checkOutput($sformatf("t1_out_%0d", i + 1), if_a.out, (t1_out[i] == "1") ? 1 : 0);
        end
        checkOutput("t1_err", if_a.err,      0);
        checkOutput("t1_cnt", if_a.char_cnt, 7);

        // T2: nesting
        pulseReset();
        t1 = "(1+(2))";
        for (int i = 0; i < t1.len(); i++) begin
            applyStimulus(t1[i]);
            checkOutput($sformatf("t2_depth_%0d", i + 1), if_a.depth, t2_depth[i]);
            checkOutput($sformatf("t2_out_%0d", i + 1),   if_a.out,   (i == 6) ? 1 : 0);
        end

        // T3: disabled '-' operator
        pulseReset();
        sendString("1-");
        checkOutput("t3_err",     if_a.err,     1);
        checkOutput("t3_err_pos", if_a.err_pos, 2);
        checkOutput("t3_out",     if_a.out,     0);
        applyStimulus("2");
        checkOutput("t3_err_hold", if_a.err,      1);
        checkOutput("t3_pos_hold", if_a.err_pos,  2);
        checkOutput("t3_cnt",      if_a.char_cnt, 3);

        // T4: digit limit and underflow
        pulseReset();
        sendString("123");
        checkOutput("t4_out",      if_b.out, 1);
        applyStimulus("4");
        checkOutput("t4_err",      if_b.err,     1);
        checkOutput("t4_err_pos",  if_b.err_pos, 4);
        checkOutput("t4_a_no_err", if_a.err,     0);
        pulseReset();
        applyStimulus(")");
        checkOutput("t4_rp_err",     if_b.err,     1);
        checkOutput("t4_rp_err_pos", if_b.err_pos, 1);

        // T5: depth limit and spaces
        pulseReset();
        sendString("(((");
        checkOutput("t5_depth_err_pos", if_c.err_pos, 3);
        checkOutput("t5_depth",         if_c.depth,   2);
        checkOutput("t5_a_depth",       if_a.depth,   3);
        pulseReset();
        sendString("1 ");
        checkOutput("t5_sp_err_pos", if_c.err_pos, 2);
        checkOutput("t5_a_sp_out",   if_a.out,     1);
        applyStimulus("2");
        checkOutput("t5_a_split_err_pos", if_a.err_pos, 3);

        pulseReset();
        sendString("((((((((");
        checkOutput("depth_max_err_pos", if_a.err_pos, 8);
        checkOutput("depth_max_depth",   if_a.depth,   7);

        // Saturating counter on the 4-bit instance
        pulseReset();
        for (int i = 0; i < 10; i++) sendString("1+");
        checkOutput("sat_cnt_c", if_c.char_cnt, 15);
        checkOutput("sat_cnt_a", if_a.char_cnt, 20);
        checkOutput("sat_err_a", if_a.err,      0);

        // T6: reset mid-stream with in_valid held high
        pulseReset();
        sendString("12+");
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = "9";
        clr      = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_cnt_in_clr", if_a.char_cnt, 0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        applyStimulus("7");
        checkOutput("t6_out", if_a.out,      1);
        checkOutput("t6_cnt", if_a.char_cnt, 1);
        in_ch = "x";
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6_gap_out", if_a.out,      1);
        checkOutput("t6_gap_cnt", if_a.char_cnt, 1);
        checkOutput("t6_gap_err", if_a.err,      0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
